// File: rtl/byte_lane_ram_pkg.sv
// Shared definitions for the byte-lane RAM: handshake state encoding and lane width.
package byte_lane_ram_pkg;

    localparam int LANE_BITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/byte_lane_ram_bank.sv
// One 8-bit byte lane of storage: synchronous write with its own strobe, combinational read.
module byte_lane_bank
    import byte_lane_ram_pkg::*;
#(
    parameter int MEM_SIZE = 128,
    parameter int IDX_W    = $clog2(MEM_SIZE)
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [IDX_W-1:0]     addr,
    input  logic [LANE_BITS-1:0] wdata,
    output logic [LANE_BITS-1:0] rdata
);

    // Contents are deliberately left uninitialised and are not touched by reset.
    logic [LANE_BITS-1:0] mem [MEM_SIZE];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/byte_lane_ram.sv
// Byte-lane RAM with a req/ready/ack handshake and configurable read/write wait states.
module byte_lane_ram
    import byte_lane_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int MEM_SIZE   = 128,
    parameter int LANES      = 4,
    parameter int READ_WAIT  = 0,
    parameter int WRITE_WAIT = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req,
    input  logic [32-ADDR_WIDTH:31]       address,
    input  logic [0:LANES-1]              write_en,
    input  logic [0:LANE_BITS*LANES-1]    data_in,
    output logic                          ready,
    output logic                          ack,
    output logic [0:LANE_BITS*LANES-1]    data_out
);

    localparam int W     = LANE_BITS * LANES;
    localparam int IDX_W = $clog2(MEM_SIZE);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic [0:LANES-1]   we_q, we_d;
    logic [0:W-1]       wdata_q, wdata_d;
    logic [0:W-1]       data_out_q, data_out_d;
    logic [0:W-1]       rd_word;
    logic [IDX_W-1:0]   in_idx;
    logic [3:0]         wait_val;
    logic               accept;
    logic               bank_en;
    logic               is_rd;
    logic               addr_unused;

    // Address bit 31 is the LSB, so the mask keeps the lowest IDX_W bits.
    assign in_idx      = address[32-IDX_W:31];
    assign addr_unused = ^address;

    assign ready    = (state_q != WAIT);
    assign ack      = (state_q == ACK);
    assign data_out = data_out_q;
    assign accept   = req && ready;
    assign wait_val = (write_en == '0) ? 4'(READ_WAIT) : 4'(WRITE_WAIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, ACK: begin
                state_d = IDLE;
                if (accept) begin
                    if (wait_val != 4'd0) begin
                        state_d = WAIT;
                        cnt_d   = wait_val;
                    end else begin
                        state_d = ACK;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // At zero waits the access completes on the accepting edge, so the live inputs are used.
    always_comb begin
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        if (accept) begin
            addr_d  = in_idx;
            we_d    = write_en;
            wdata_d = data_in;
        end
        is_rd      = (we_d == '0);
        bank_en    = (state_d == ACK) && reset;
        data_out_d = (bank_en && is_rd) ? rd_word : data_out_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
        end
    end

    always_ff @(posedge clock) begin
        addr_q  <= addr_d;
        we_q    <= we_d;
        wdata_q <= wdata_d;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        byte_lane_bank #(
            .MEM_SIZE (MEM_SIZE),
            .IDX_W    (IDX_W)
        ) u_bank (
            .clock (clock),
            .we    (bank_en && we_d[i]),
            .addr  (addr_d),
            .wdata (wdata_d[LANE_BITS*i +: LANE_BITS]),
            .rdata (rd_word[LANE_BITS*i +: LANE_BITS])
        );
    end

endmodule

// File: tb/tb_byte_lane_ram.sv
// Directed bench for byte_lane_ram: zero-wait, read-wait and write-wait instances with a scoreboard.
module tb_byte_lane_ram;

    typedef struct packed {
        logic        rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:31] address;
    logic [0:3]  write_en;
    logic [0:31] data_in;
    logic        req_v   [3];
    logic        ready_v [3];
    logic        ack_v   [3];
    logic [0:31] dout_v  [3];

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    byte_lane_ram dut0 (
        .clock(clk), .reset(reset), .req(req_v[0]), .address(address),
        .write_en(write_en), .data_in(data_in),
        .ready(ready_v[0]), .ack(ack_v[0]), .data_out(dout_v[0])
    );

    byte_lane_ram #(.READ_WAIT(3)) dut_r (
        .clock(clk), .reset(reset), .req(req_v[1]), .address(address),
        .write_en(write_en), .data_in(data_in),
        .ready(ready_v[1]), .ack(ack_v[1]), .data_out(dout_v[1])
    );

    byte_lane_ram #(.WRITE_WAIT(4)) dut_w (
        .clock(clk), .reset(reset), .req(req_v[2]), .address(address),
        .write_en(write_en), .data_in(data_in),
        .ready(ready_v[2]), .ack(ack_v[2]), .data_out(dout_v[2])
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload0(input int a, input logic [0:31] w);
        dut0.g_lane[0].u_bank.mem[a] = w[0 +: 8];
        dut0.g_lane[1].u_bank.mem[a] = w[8 +: 8];
        dut0.g_lane[2].u_bank.mem[a] = w[16 +: 8];
        dut0.g_lane[3].u_bank.mem[a] = w[24 +: 8];
    endtask

    task automatic preload_r(input int a, input logic [0:31] w);
        dut_r.g_lane[0].u_bank.mem[a] = w[0 +: 8];
        dut_r.g_lane[1].u_bank.mem[a] = w[8 +: 8];
        dut_r.g_lane[2].u_bank.mem[a] = w[16 +: 8];
        dut_r.g_lane[3].u_bank.mem[a] = w[24 +: 8];
    endtask

    task automatic preload_w(input int a, input logic [0:31] w);
        dut_w.g_lane[0].u_bank.mem[a] = w[0 +: 8];
        dut_w.g_lane[1].u_bank.mem[a] = w[8 +: 8];
        dut_w.g_lane[2].u_bank.mem[a] = w[16 +: 8];
        dut_w.g_lane[3].u_bank.mem[a] = w[24 +: 8];
    endtask

    // One request on instance idx; ack latency is counted in cycles after the accepting edge.
    task automatic run_op(input int idx, input logic [15:31] a, input logic [0:3] we,
                          input logic [0:31] d, input logic [31:0] exp_data,
                          input int exp_lat, input string tag);
        int   lat;
        exp_t e;
        address    = a;
        write_en   = we;
        data_in    = d;
        req_v[idx] = 1'b1;
        sb.push_back('{rd: (we == 4'b0000), data: exp_data});
        tick;
        req_v[idx] = 1'b0;
        address    = 17'h1FFFF;
        write_en   = 4'b1111;
        data_in    = 32'h0BAD0BAD;
        lat = 1;
        while (ack_v[idx] !== 1'b1 && lat < 20) begin
            tick;
            lat++;
        end
        e = sb.pop_front();
        check({tag, "_lat"}, lat, exp_lat);
        if (e.rd) check({tag, "_data"}, dout_v[idx], e.data);
        tick;
        check({tag, "_ackpulse"}, {31'd0, ack_v[idx]}, 32'd0);
    endtask

    initial begin
        exp_t e;
        reset    = 1'b0;
        address  = '0;
        write_en = '0;
        data_in  = '0;
        for (int i = 0; i < 3; i++) req_v[i] = 1'b0;

        tick;
        tick;
        check("rst_ready", {31'd0, ready_v[0]}, 32'd1);
        check("rst_ack",   {31'd0, ack_v[0]},   32'd0);
        check("rst_dout",  dout_v[0],           32'd0);
        reset = 1'b1;
        tick;
        check("rel_ready", {31'd0, ready_v[0]}, 32'd1);

        preload0(5, 32'h12345678);
        preload0(3, 32'h11223344);
        preload_r(7, 32'hCAFEF00D);
        preload_r(5, 32'h55555555);
        preload_w(2, 32'h01020304);

        run_op(0, 17'd5, 4'b0000, 32'h0, 32'h12345678, 1, "A_read5");

        run_op(0, 17'd3, 4'b0101, 32'hAABBCCDD, 32'h0, 1, "B_wr3");
        check("B_hold", dout_v[0], 32'h12345678);
        run_op(0, 17'd3, 4'b0000, 32'h0, 32'h11BB33DD, 1, "B_rd3");

        run_op(0, 17'h85, 4'b0000, 32'h0, 32'h12345678, 1, "C_wrap");

        // Back-to-back write then read of word 9 with req held high.
        address  = 17'd9;
        write_en = 4'b1111;
        data_in  = 32'hDEADBEEF;
        req_v[0] = 1'b1;
        sb.push_back('{rd: 1'b0, data: 32'h0});
        tick;
        write_en = 4'b0000;
        data_in  = 32'h0;
        sb.push_back('{rd: 1'b1, data: 32'hDEADBEEF});
        check("D_ack1", {31'd0, ack_v[0]}, 32'd1);
        e = sb.pop_front();
        tick;
        req_v[0] = 1'b0;
        check("D_ack2", {31'd0, ack_v[0]}, 32'd1);
        e = sb.pop_front();
        check("D_data", dout_v[0], e.data);
        tick;
        check("D_idle", {31'd0, ack_v[0]}, 32'd0);

        // Three read wait states; req stays high on another word and must be ignored.
        address  = 17'd7;
        write_en = 4'b0000;
        req_v[1] = 1'b1;
        sb.push_back('{rd: 1'b1, data: 32'hCAFEF00D});
        tick;
        address  = 17'd5;
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("E_ready_c%0d", i), {31'd0, ready_v[1]}, 32'd0);
            check($sformatf("E_ack_c%0d", i),   {31'd0, ack_v[1]},   32'd0);
            tick;
        end
        req_v[1] = 1'b0;
        e = sb.pop_front();
        check("E_ack_c4",   {31'd0, ack_v[1]},   32'd1);
        check("E_ready_c4", {31'd0, ready_v[1]}, 32'd1);
        check("E_data",     dout_v[1],           e.data);
        tick;
        check("E_ackpulse", {31'd0, ack_v[1]}, 32'd0);

        // Reset during the second write wait cycle aborts the write.
        run_op(2, 17'd2, 4'b0000, 32'h0, 32'h01020304, 1, "F_pre");
        address  = 17'd2;
        write_en = 4'b1111;
        data_in  = 32'hFFFFFFFF;
        req_v[2] = 1'b1;
        tick;
        req_v[2] = 1'b0;
        check("F_wait1", {31'd0, ready_v[2]}, 32'd0);
        tick;
        reset = 1'b0;
        #1;
        check("F_rst_ack",   {31'd0, ack_v[2]},   32'd0);
        check("F_rst_dout",  dout_v[2],           32'd0);
        check("F_rst_ready", {31'd0, ready_v[2]}, 32'd1);
        tick;
        tick;
        reset = 1'b1;
        tick;
        check("F_rel_ready", {31'd0, ready_v[2]}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("F_noack%0d", i), {31'd0, ack_v[2]}, 32'd0);
            tick;
        end
        run_op(2, 17'd2, 4'b0000, 32'h0, 32'h01020304, 1, "F_mem");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
